// File: rtl/fp34_pkg.sv
// Shared definitions for the 34-bit FloPoCo-format slab reduction logic.
package fp34_pkg;

  // Default MSB index of an FP bus; buses are [FP_W:0]
  localparam int FP_W = 33;

  // Field positions for the default bus width
  localparam int EXC_HI   = FP_W;
  localparam int EXC_LO   = FP_W - 1;
  localparam int SIGN_BIT = FP_W - 2;
  localparam int EXP_HI   = FP_W - 3;
  localparam int EXP_LO   = 20;
  localparam int FRAC_HI  = 19;
  localparam int FRAC_LO  = 0;

  // Exception field encodings
  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  // Compares issued per bundle: two for tnear, two for tfar, one for the hit
  localparam int NUM_CMPS = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMP1 = 3'd1,
    ST_CMP2 = 3'd2,
    ST_CMP3 = 3'd3,
    ST_CMP4 = 3'd4,
    ST_CMP5 = 3'd5,
    ST_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/fp34_class.sv
// Combinational classification of one FloPoCo FP bus: NaN and
// "strictly negative" (sign set on a non-zero value, so -0 is not negative).
module fp34_class
  import fp34_pkg::*;
#(
  parameter int W = FP_W
) (
  input  logic [W:0] x,
  output logic       is_nan,
  output logic       is_neg_nonzero
);

  logic [1:0] exc;
  logic       sign;
  logic       unused_mag;

  assign exc        = x[W:W-1];
  assign sign       = x[W-2];
  // Exponent and fraction play no part in the classification
  assign unused_mag = ^x[W-3:0];

  assign is_nan         = (exc == EXC_NAN);
  assign is_neg_nonzero = sign && (exc != EXC_ZERO);

endmodule

// File: rtl/slab_reduce_ctrl.sv
// Ray-AABB slab reduction: sequences an external pipelined FP less-than unit
// to find tnear = max(tmin), tfar = min(tmax) and the hit decision.
//
// state | meaning
// IDLE  | waiting for an input bundle (in_ready=1)
// CMP1  | tmin0 vs tmin1 -> acc_n
// CMP2  | acc_n vs tmin2 -> acc_n
// CMP3  | tmax1 vs tmax0 -> acc_f
// CMP4  | tmax2 vs acc_f -> acc_f
// CMP5  | acc_n vs acc_f -> hit
// DONE  | result presented, waiting for out_ready
module slab_reduce_ctrl
  import fp34_pkg::*;
#(
  parameter int W       = 33,
  parameter int CMP_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3*(W+1)-1:0]   tmin_flat,
  input  logic [3*(W+1)-1:0]   tmax_flat,
  output logic [W:0]           cmp_a,
  output logic [W:0]           cmp_b,
  input  logic                 cmp_less,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W:0]           tnear,
  output logic [W:0]           tfar,
  output logic                 hit,
  output logic                 nan_flag
);

  localparam int              CW     = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
  localparam logic [CW-1:0]   CNT_TC = CW'(CMP_LAT - 1);

  logic [W:0] tmin_in [3];
  logic [W:0] tmax_in [3];
  logic [5:0] in_nan;
  logic [5:0] in_neg_unused;
  logic       in_any_nan;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    tmin_q [3];
  logic [W:0]    tmin_d [3];
  logic [W:0]    tmax_q [3];
  logic [W:0]    tmax_d [3];
  logic [W:0]    acc_n_q, acc_n_d;
  logic [W:0]    acc_f_q, acc_f_d;
  logic [W:0]    cmp_a_q, cmp_a_d;
  logic [W:0]    cmp_b_q, cmp_b_d;
  logic [W:0]    tnear_q, tnear_d;
  logic [W:0]    tfar_q, tfar_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          hit_q, hit_d;
  logic          nan_q, nan_d;

  logic          accept;
  logic          sample;
  logic          in_cmp;
  logic          far_neg;
  logic          far_nan_unused;

  // Unpack the input bundles and classify each element for the NaN bypass
  for (genvar gi = 0; gi < 3; gi++) begin : g_in
    assign tmin_in[gi] = tmin_flat[gi*(W+1) +: W+1];
    assign tmax_in[gi] = tmax_flat[gi*(W+1) +: W+1];

    fp34_class #(.W(W)) u_cls_min (
      .x              (tmin_in[gi]),
      .is_nan         (in_nan[gi]),
      .is_neg_nonzero (in_neg_unused[gi])
    );

    fp34_class #(.W(W)) u_cls_max (
      .x              (tmax_in[gi]),
      .is_nan         (in_nan[gi+3]),
      .is_neg_nonzero (in_neg_unused[gi+3])
    );
  end

  // A -0 tfar must still count as in front of the ray, hence the non-zero qualifier
  fp34_class #(.W(W)) u_cls_far (
    .x              (acc_f_q),
    .is_nan         (far_nan_unused),
    .is_neg_nonzero (far_neg)
  );

  assign in_any_nan = |in_nan;
  assign accept     = in_valid && in_ready_q;
  assign sample     = (cnt_q == CNT_TC);
  assign in_cmp     = (state_q == ST_CMP1) || (state_q == ST_CMP2) ||
                      (state_q == ST_CMP3) || (state_q == ST_CMP4) ||
                      (state_q == ST_CMP5);

  // Next-state and next-output computation for the compare sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmin_d      = tmin_q;
    tmax_d      = tmax_q;
    acc_n_d     = acc_n_q;
    acc_f_d     = acc_f_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    tnear_d     = tnear_q;
    tfar_d      = tfar_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    hit_d       = hit_q;
    nan_d       = nan_q;

    // Operands stay put for CMP_LAT edges; the result is taken on the last one
    if (in_cmp) begin
      cnt_d = sample ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          in_ready_d = 1'b0;
          tmin_d     = tmin_in;
          tmax_d     = tmax_in;
          if (in_any_nan) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            nan_d       = 1'b1;
            hit_d       = 1'b0;
            tnear_d     = '0;
            tfar_d      = '0;
          end else begin
            state_d = ST_CMP1;
            cnt_d   = '0;
            nan_d   = 1'b0;
            cmp_a_d = tmin_in[0];
            cmp_b_d = tmin_in[1];
          end
        end
      end
      ST_CMP1: begin
        if (sample) begin
          acc_n_d = cmp_less ? tmin_q[1] : tmin_q[0];
          cmp_a_d = acc_n_d;
          cmp_b_d = tmin_q[2];
          state_d = ST_CMP2;
        end
      end
      ST_CMP2: begin
        if (sample) begin
          acc_n_d = cmp_less ? tmin_q[2] : acc_n_q;
          cmp_a_d = tmax_q[1];
          cmp_b_d = tmax_q[0];
          state_d = ST_CMP3;
        end
      end
      ST_CMP3: begin
        if (sample) begin
          acc_f_d = cmp_less ? tmax_q[1] : tmax_q[0];
          cmp_a_d = tmax_q[2];
          cmp_b_d = acc_f_d;
          state_d = ST_CMP4;
        end
      end
      ST_CMP4: begin
        if (sample) begin
          acc_f_d = cmp_less ? tmax_q[2] : acc_f_q;
          cmp_a_d = acc_n_q;
          cmp_b_d = acc_f_d;
          state_d = ST_CMP5;
        end
      end
      ST_CMP5: begin
        if (sample) begin
          tnear_d     = acc_n_q;
          tfar_d      = acc_f_q;
          hit_d       = cmp_less && !far_neg;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset drops any bundle in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      for (int i = 0; i < 3; i++) begin
        tmin_q[i] <= '0;
        tmax_q[i] <= '0;
      end
      acc_n_q     <= '0;
      acc_f_q     <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      tnear_q     <= '0;
      tfar_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      nan_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmin_q      <= tmin_d;
      tmax_q      <= tmax_d;
      acc_n_q     <= acc_n_d;
      acc_f_q     <= acc_f_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      tnear_q     <= tnear_d;
      tfar_q      <= tfar_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      hit_q       <= hit_d;
      nan_q       <= nan_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign cmp_a     = cmp_a_q;
  assign cmp_b     = cmp_b_q;
  assign tnear     = tnear_q;
  assign tfar      = tfar_q;
  assign hit       = hit_q;
  assign nan_flag  = nan_q;

endmodule

// File: tb/tb_slab_reduce_ctrl.sv
// Scoreboard bench for slab_reduce_ctrl with a behavioural pipelined comparator.
module tb_slab_reduce_ctrl;

  localparam int W       = 33;
  localparam int CMP_LAT = 3;
  localparam int LAT     = 5 * CMP_LAT;

  // Hand-encoded operands: {exc, sign, exp[10:0], frac[19:0]}, bias 1023
  localparam logic [W:0] PZ   = {2'b00, 1'b0, 11'd0,    20'h00000};
  localparam logic [W:0] NZ   = {2'b00, 1'b1, 11'd0,    20'h00000};
  localparam logic [W:0] P0_5 = {2'b01, 1'b0, 11'd1022, 20'h00000};
  localparam logic [W:0] P1   = {2'b01, 1'b0, 11'd1023, 20'h00000};
  localparam logic [W:0] P2   = {2'b01, 1'b0, 11'd1024, 20'h00000};
  localparam logic [W:0] P3   = {2'b01, 1'b0, 11'd1024, 20'h80000};
  localparam logic [W:0] P4   = {2'b01, 1'b0, 11'd1025, 20'h00000};
  localparam logic [W:0] P5   = {2'b01, 1'b0, 11'd1025, 20'h40000};
  localparam logic [W:0] P6   = {2'b01, 1'b0, 11'd1025, 20'h80000};
  localparam logic [W:0] P7   = {2'b01, 1'b0, 11'd1025, 20'hC0000};
  localparam logic [W:0] M0_5 = {2'b01, 1'b1, 11'd1022, 20'h00000};
  localparam logic [W:0] M1   = {2'b01, 1'b1, 11'd1023, 20'h00000};
  localparam logic [W:0] M2   = {2'b01, 1'b1, 11'd1024, 20'h00000};
  localparam logic [W:0] M5   = {2'b01, 1'b1, 11'd1025, 20'h40000};
  localparam logic [W:0] M6   = {2'b01, 1'b1, 11'd1025, 20'h80000};
  localparam logic [W:0] M7   = {2'b01, 1'b1, 11'd1025, 20'hC0000};
  localparam logic [W:0] QNAN = {2'b11, 1'b0, 11'h7FF,  20'h00001};

  typedef struct {
    logic [W:0] tnear;
    logic [W:0] tfar;
    logic       hit;
    logic       nan;
    int         lat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [3*(W+1)-1:0] tmin_flat;
  logic [3*(W+1)-1:0] tmax_flat;
  logic [W:0]         cmp_a;
  logic [W:0]         cmp_b;
  logic               cmp_less;
  logic               out_valid;
  logic               out_ready;
  logic [W:0]         tnear;
  logic [W:0]         tfar;
  logic               hit;
  logic               nan_flag;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];
  int   acc_hist[$];
  int   rise_edge = 0;
  logic prev_ov   = 1'b0;
  logic [CMP_LAT-2:0] pipe = '0;

  slab_reduce_ctrl #(.W(W), .CMP_LAT(CMP_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tmin_flat (tmin_flat),
    .tmax_flat (tmax_flat),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_less  (cmp_less),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .tnear     (tnear),
    .tfar      (tfar),
    .hit       (hit),
    .nan_flag  (nan_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Total order used by the comparator model: zeros equal, infinities extreme
  function automatic longint ord(input logic [W:0] x);
    longint m;
    case (x[W:W-1])
      2'b00:   m = 0;
      2'b01:   m = 1 + longint'(x[W-3:0]);
      2'b10:   m = 64'h1_0000_0000;
      default: m = 0;
    endcase
    return x[W-2] ? -m : m;
  endfunction

  // Comparator: result valid CMP_LAT edges after an operand change
  always @(posedge clk) begin
    pipe <= {pipe[CMP_LAT-3:0], (ord(cmp_a) < ord(cmp_b))};
  end
  assign cmp_less = pipe[CMP_LAT-2];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: logs accepts, times the out_valid rise and checks each delivered result
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_hist.push_back(cyc + 1);
      if (out_valid && !prev_ov) rise_edge = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("tnear", 64'(tnear), 64'(e.tnear));
          check("tfar", 64'(tfar), 64'(e.tfar));
          check("hit", 64'(hit), 64'(e.hit));
          check("nan_flag", 64'(nan_flag), 64'(e.nan));
          if (acc_hist.size() == 0) check("latency_no_accept", 64'd1, 64'd0);
          else check("latency", 64'(rise_edge - acc_hist[$]), 64'(e.lat));
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [W:0] a0, a1, a2, b0, b1, b2,
                      input bit push, input logic [W:0] en, ef,
                      input logic eh, enan, input int lat);
    exp_t e;
    int   n;
    if (push) begin
      e.tnear = en; e.tfar = ef; e.hit = eh; e.nan = enan; e.lat = lat;
      sb.push_back(e);
    end
    tmin_flat = {a2, a1, a0};
    tmax_flat = {b2, b1, b0};
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'd1, 64'd0);
    else begin
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    tmin_flat = {3{$urandom_range(0, 32'h7fff_ffff)}};
    tmax_flat = {3{$urandom}};
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tmin_flat = '0;
    tmax_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_tnear", 64'(tnear), 64'd0);
    check("rst_cmp_a", 64'(cmp_a), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back bundles: nominal hit followed by tnear > tfar
    send(P1, P2, P0_5, P4, P3, P5, 1, P2, P3, 1'b1, 1'b0, LAT);
    send(P1, P3, PZ, P2, P5, P4, 1, P3, P2, 1'b0, 1'b0, LAT);
    if (acc_hist.size() < 2) check("throughput_hist", 64'd0, 64'd1);
    else check("throughput", 64'(acc_hist[$] - acc_hist[$-1]), 64'(LAT + 2));
    wait_done();

    // Ties keep the earlier operand; +0/-0 tie exposes which one was kept
    send(P2, P2, P1, P2, P6, P7, 1, P2, P2, 1'b0, 1'b0, LAT);
    wait_done();
    send(PZ, NZ, M1, NZ, PZ, P1, 1, PZ, NZ, 1'b0, 1'b0, LAT);
    wait_done();

    // Box behind the ray, then tfar of -0 counting as non-negative
    send(M5, M6, M7, M1, M2, M0_5, 1, M5, M2, 1'b0, 1'b0, LAT);
    wait_done();
    send(M5, M6, M7, NZ, P1, P2, 1, M5, NZ, 1'b1, 1'b0, LAT);
    wait_done();

    // NaN bypass: immediate result, comparator operands untouched
    check("pre_nan_cmp_a", 64'(cmp_a), 64'(M5));
    check("pre_nan_cmp_b", 64'(cmp_b), 64'(NZ));
    send(P1, P2, P0_5, P4, QNAN, P5, 1, PZ, PZ, 1'b0, 1'b1, 0);
    wait_done();
    check("nan_cmp_a", 64'(cmp_a), 64'(M5));
    check("nan_cmp_b", 64'(cmp_b), 64'(NZ));

    // Back-pressure: result held, no second accept while DONE
    out_ready = 1'b0;
    send(P1, P2, P0_5, P4, P3, P5, 1, P2, P3, 1'b1, 1'b0, LAT);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_rise", 64'(out_valid), 64'd1);
    tmin_flat = {PZ, P3, P1};
    tmax_flat = {P4, P5, P2};
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_tnear", 64'(tnear), 64'(P2));
      check("hold_tfar", 64'(tfar), 64'(P3));
      check("hold_hit", 64'(hit), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_done();
    repeat (2) @(posedge clk);
    #1;
    check("post_hold_out_valid", 64'(out_valid), 64'd0);
    check("post_hold_in_ready", 64'(in_ready), 64'd1);

    // Reset during CMP3 discards the bundle and clears outputs at once
    send(M5, M6, M7, M1, M2, M0_5, 0, PZ, PZ, 1'b0, 1'b0, 0);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_tnear", 64'(tnear), 64'd0);
    check("mid_rst_tfar", 64'(tfar), 64'd0);
    check("mid_rst_hit", 64'(hit), 64'd0);
    check("mid_rst_nan", 64'(nan_flag), 64'd0);
    check("mid_rst_cmp_a", 64'(cmp_a), 64'd0);
    check("mid_rst_cmp_b", 64'(cmp_b), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fresh bundle after reset runs with full latency
    send(P1, P2, P0_5, P4, P3, P5, 1, P2, P3, 1'b1, 1'b0, LAT);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slab_reduce_ctrl.md
Name: slab_reduce_ctrl

Overview:
- Sequences one shared pipelined FP less-than unit (FPSub_11_20-based, 34-bit FloPoCo format) to finish a Ray-AABB slab test.
- Takes three per-axis entry distances (tmin0..2) and three exit distances (tmax0..2).
- Computes tnear = max(tmin), tfar = min(tmax), and hit = (tnear < tfar) && (tfar not negative).
- Sits between the per-axis slab subtract/multiply stage and the hit-result consumer. The comparator is instantiated outside this block and driven through the cmp_* ports.

Parameters:
- W, 33, MSB index of every FP bus; buses are [W:0]. Layout: [W:W-1] exception (00 zero, 01 normal, 10 inf, 11 NaN), [W-2] sign, [W-3:20] exponent, [19:0] fraction.
- CMP_LAT, 3, edges from a cmp_a/cmp_b update to a valid cmp_less (FPSub pipeline depth + output register); minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- in_valid  in  1  input bundle valid
- in_ready  out  1  block can accept a bundle
- tmin_flat  in  3*(W+1)  {tmin2,tmin1,tmin0}
- tmax_flat  in  3*(W+1)  {tmax2,tmax1,tmax0}
- cmp_a  out  W+1  comparator operand A (registered)
- cmp_b  out  W+1  comparator operand B (registered)
- cmp_less  in  1  comparator result: 1 iff A-B is normal and negative
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- tnear  out  W+1  max(tmin)
- tfar  out  W+1  min(tmax)
- hit  out  1  ray intersects box
- nan_flag  out  1  at least one input was NaN

Behaviour:
- Reset (async, any state): state=IDLE. in_ready=0 during reset, then 1 in IDLE. out_valid, hit, nan_flag, cmp_a, cmp_b, tnear, tfar all 0. Counter cleared. Reset mid-operation discards the bundle; any result still in the comparator pipeline is ignored because the counter restarts.
- States: IDLE, CMP1..CMP5, DONE.
- in_ready=1 only in IDLE. Accept edge E0 is the edge with in_valid && in_ready. At E0 the six inputs are registered.
- NaN check at E0: if any input exception field == 11, go directly to DONE. nan_flag=1, hit=0, tnear=tfar=0, out_valid rises at E0. No compares are issued.
- Otherwise, at E0: cmp_a=tmin0, cmp_b=tmin1, state=CMP1, counter=0.
- In each CMPk the counter increments every edge. At the edge where counter==CMP_LAT-1:
  - cmp_less is sampled;
  - the selection is applied;
  - the next operands are loaded;
  - counter resets to 0.
  - Operands are held stable for the whole interval.
- Compare schedule:
  - CMP1: A=tmin0, B=tmin1. acc_n = less ? tmin1 : tmin0.
  - CMP2: A=acc_n, B=tmin2. acc_n = less ? tmin2 : acc_n.
  - CMP3: A=tmax1, B=tmax0. acc_f = less ? tmax1 : tmax0.
  - CMP4: A=tmax2, B=acc_f. acc_f = less ? tmax2 : acc_f.
  - CMP5: A=acc_n, B=acc_f. hit = less && !(acc_f[W-2] && acc_f[W:W-1]!=00).
- Ties: ties keep the earlier operand (strict less). tnear==tfar gives hit=0.
- Sign test: a -0 tfar counts as non-negative. +inf and -inf are ordered by the comparator only; no special handling here.
- Result timing: at the CMP5 sample edge (E0+5*CMP_LAT), tnear/tfar/hit are registered and out_valid=1; state=DONE. Latency is 5*CMP_LAT cycles (15 at default).
- DONE: outputs held stable while out_valid && !out_ready. On out_valid && out_ready: out_valid=0, state=IDLE, so in_ready=1 on the next cycle. Back-to-back throughput is one bundle per 5*CMP_LAT+2 cycles.
- cmp_a/cmp_b keep their last values in IDLE/DONE. The comparator output is don't-care outside the CMPk sample edges.
- in_valid is ignored while in_ready=0. Input data need not stay stable after E0.

Decomposition:
- Shared package fp34_pkg:
  - exception codes EXC_ZERO/NORMAL/INF/NAN;
  - field index constants (EXC_HI, EXC_LO, SIGN_BIT, EXP_HI..);
  - the state encoding;
  - NUM_CMPS=5.
- One natural sub-module: fp34_class, a combinational decode of a bus into is_nan / is_neg_nonzero. It is instantiated 6x for the NaN check and 1x for the tfar sign test.
- The comparator stays external so it can be shared or replaced.

Test Plan:
- tmin={1.0,2.0,0.5}, tmax={4.0,3.0,5.0}, CMP_LAT=3 -> out_valid exactly 15 cycles after accept; tnear=2.0, tfar=3.0, hit=1, nan_flag=0.
- tmin={1.0,3.0,0.0}, tmax={2.0,5.0,4.0} -> tnear=3.0, tfar=2.0, hit=0.
- Tie case: tmin={2.0,2.0,1.0}, tmax={2.0,6.0,7.0} -> tnear=2.0, tfar=2.0, hit=0 (strict compare).
- Box behind ray: tmin={-5.0,-6.0,-7.0}, tmax={-1.0,-2.0,-0.5} -> tnear=-5.0, tfar=-2.0, hit=0. Second run with tmax0=-0.0 (exception 00, sign 1) and others larger -> tfar=-0.0, hit=1.
- NaN: tmax1 exception=11 -> out_valid one edge after accept, nan_flag=1, hit=0, no change on cmp_a/cmp_b.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, a second in_valid is not accepted.
  - Assert rst during CMP3 -> all outputs 0 immediately.
  - A new bundle after reset completes correctly with the full 15-cycle latency.
